// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First asserted request after base in wrapping order; base itself is tried last when incl_base.
  function automatic pick_t rr_search(input logic [NREQ-1:0] req,
                                      input logic [IDX_W-1:0] base,
                                      input logic incl_base);
    pick_t            pick;
    logic [IDX_W-1:0] idx;
    pick = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = base + IDX_W'(k);
      if (!pick.found && req[idx] && ((k != NREQ) || incl_base)) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             busy;
  logic             preempt;

  modport master (output req, input gnt, gnt_id, busy, preempt);
  modport slave  (input req, output gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/rr_arbiter4_decoder_2to4.sv
// Two-to-four one-hot decoder.
module decoder_2to4
  import rr_arbiter4_pkg::*;
(
  input  logic [IDX_W-1:0] din,
  output logic [NREQ-1:0]  dout
);

  always_comb begin
    dout       = '0;
    dout[din]  = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with optional per-owner hold limit.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned HOLD_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic          CLK,
  input logic          RST,
  rr_arbiter4_if.slave bus
);

  localparam int unsigned LIMIT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              preempt_q, preempt_d;

  pick_t             idle_pick;
  pick_t             other_pick;
  logic              at_limit;
  logic [NREQ-1:0]   dec_gnt;

  assign idle_pick  = rr_search(bus.req, last_q, 1'b1);
  assign other_pick = rr_search(bus.req, gnt_id_q, 1'b0);
  assign at_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(LIMIT));

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_pick.found) begin
          state_d    = ST_GRANT;
          gnt_id_d   = idle_pick.idx;
          last_d     = idle_pick.idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          // Owner released: hand over with no idle gap, else fall back to idle keeping gnt_id.
          hold_cnt_d = '0;
          if (other_pick.found) begin
            gnt_id_d = other_pick.idx;
            last_d   = other_pick.idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (at_limit) begin
          hold_cnt_d = '0;
          if (other_pick.found) begin
            gnt_id_d  = other_pick.idx;
            last_d    = other_pick.idx;
            preempt_d = 1'b1;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= '0;
      last_q     <= IDX_W'(NREQ - 1);
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  decoder_2to4 u_dec (
    .din  (gnt_id_q),
    .dout (dec_gnt)
  );

  assign bus.busy    = (state_q == ST_GRANT);
  assign bus.gnt     = bus.busy ? dec_gnt : '0;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.preempt = preempt_q;

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter; shares one resource between four requesters.
- Keeps a registered 2-bit grant index and expands it to the one-hot grant vector with the team's 2-to-4 decoder.
- Optional hold limit: a requester that keeps its request high past the limit loses the grant when others are waiting.
- Sits between requesters (e.g. bus masters or display sources) and the shared datapath.

Parameters:
- HOLD_W, 8, width of hold counter.
- MAX_HOLD, 16, maximum consecutive grant cycles per requester; 0 = unlimited (no preemption).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; asynchronous, active-high.
- req  input  4  request per requester, level; bit i = requester i.
- gnt  output  4  one-hot grant; decoded from gnt_id when busy, else 4'b0000.
- gnt_id  output  2  index of current/last granted requester.
- busy  output  1  1 while any grant is active.
- preempt  output  1  one-cycle pulse in the cycle after a forced rotation by hold limit.

Behaviour:
- Reset (async, RST=1): state=IDLE, gnt=0000, gnt_id=00, busy=0, preempt=0, hold_cnt=0, last=2'b11 (requester 0 has top priority first).
- Search order: last+1, last+2, last+3, last (mod 4); the first asserted req in that order wins. Index arithmetic is 2-bit and wraps (3+1=0).
- States: IDLE, GRANT.
- IDLE behaviour:
  - req==0: stay IDLE.
  - Any req: the winner is registered. Next cycle gnt_id=winner, busy=1, state=GRANT, hold_cnt=0, last=winner.
  - Latency req->gnt is exactly 1 clock.
- GRANT, owner = gnt_id, evaluated every edge:
  - Release (req[owner]=0): search the other three in order from owner+1.
    - If one is found, grant it next cycle with no idle gap (state stays GRANT, hold_cnt=0, last updated).
    - If none is found, go to IDLE next cycle (gnt=0000, busy=0, gnt_id holds value).
  - Hold (req[owner]=1, MAX_HOLD=0 or hold_cnt<MAX_HOLD-1): keep grant; hold_cnt+1.
  - Limit (req[owner]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1):
    - If another req is pending: rotate to the next in order; preempt=1 for one cycle; hold_cnt=0.
    - If none is pending: keep owner, hold_cnt=0, no preempt.
- Simultaneous release by the owner and new requests in the same cycle: handled by the release rule; no bubble.
- Requests that rise and fall while not granted are not latched; the arbiter only sees the current level.
- gnt is always one-hot or zero, never multi-hot. gnt changes only on CLK rising edge, except on async reset.
- Reset mid-grant: all outputs clear immediately, without waiting for a clock. The first grant after reset follows the reset priority (req0 first).
- hold_cnt saturates logic-wise; it never exceeds MAX_HOLD-1. MAX_HOLD must be <= 2**HOLD_W.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - requester count constant NREQ=4.
  - index width IDX_W=2.
- Sub-module: decoder_2to4 (combinational, din[1:0] -> dout[3:0] one-hot); instantiated once to produce gnt from gnt_id, gated by busy.
- Round-robin search and the FSM stay in rr_arbiter4.

Test Plan:
- Reset: RST=1 mid-grant (gnt=0100) -> gnt=0000, busy=0, gnt_id=00 immediately. After release, req=1111 -> gnt=0001 one clock later.
- Rotation: MAX_HOLD=0, req=1111, with each owner dropping its req for one cycle after 2 cycles of grant -> grant order 0001, 0010, 0100, 1000, 0001, with no idle cycle between grants.
- Single requester: req=0100 only -> gnt=0100 after 1 clock. Dropping req -> gnt=0000 and busy=0 next clock, gnt_id stays 10.
- Hold limit: MAX_HOLD=4, req0 held high, req2 asserted -> gnt=0001 for 4 cycles, then gnt=0100 with preempt=1 for exactly one cycle. With req2 absent, gnt stays 0001 and preempt stays 0.
- Wrap-around: last=3 (owner 1000 releases), req=0011 -> next gnt=0001 (index 0 precedes 1 after wrap).
- Simultaneous release and request: owner 0010 drops req in the same cycle req3 rises -> next cycle gnt=1000, busy stays 1.
